noc_packet_encoder: RTL and testbench

- NoC transmit-side framer for a tile: the counterpart of the tile's header decoder.
- Accepts a send command (destination, opcode, offset, length) and a payload word stream.
- Emits one 32-bit header word followed by the payload on the tile's 32-bit AXI-stream NoC output, with TLAST on the final word.
- Sits between tile logic and the NoC router output port, on the line clock.

---
 rtl/noc_pkg.sv | 39 +++
 rtl/noc_packet_encoder_if.sv | 49 ++++
 rtl/noc_packet_encoder_axis_reg_slice.sv | 49 ++++
 rtl/noc_packet_encoder.sv | 114 +++++++++++
 tb/tb_noc_packet_encoder.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg: definitions shared by the tile's NoC header encoder and decoder.
//   - default field widths (coordinate, node ID, offset, payload length)
//   - header field bit positions for the default widths
//   - packet opcode enum and the encoder state enum
// ---------------------------------------------------------------------------
package noc_pkg;

    localparam int XY_SZ     = 4;
    localparam int OFFSET_SZ = 12;
    localparam int LEN_SZ    = 8;
    localparam int OPC_SZ    = 4;
    localparam int NODE_W    = 2 * XY_SZ;
    localparam int HDR_W     = 32;

    // Header layout, LSB upward: offset | opcode | source | destination
    localparam int OFF_LSB  = 0;
    localparam int OFF_MSB  = OFF_LSB + OFFSET_SZ - 1;
    localparam int OPC_LSB  = OFF_MSB + 1;
    localparam int OPC_MSB  = OPC_LSB + OPC_SZ - 1;
    localparam int SRC_LSB  = OPC_MSB + 1;
    localparam int SRC_MSB  = SRC_LSB + NODE_W - 1;
    localparam int DEST_LSB = SRC_MSB + 1;
    localparam int DEST_MSB = DEST_LSB + NODE_W - 1;

    typedef enum logic [OPC_SZ-1:0] {
        OPC_NOP      = 4'h0,
        OPC_WRITE    = 4'h1,
        OPC_READ     = 4'h2,
        OPC_READ_RSP = 4'h3,
        OPC_ATOMIC   = 4'h4
    } noc_opcode_e;

    typedef enum logic {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } enc_state_e;

endpackage

// File: rtl/noc_packet_encoder_if.sv
// ---------------------------------------------------------------------------
// noc_packet_encoder_if: handshake bundle around the packet encoder.
//   cmd_*        send command (valid/ready + destination, opcode, offset, len)
//   pl_*         payload word stream into the encoder
//   stream_out_* 32-bit AXI-stream toward the NoC router
// modport master : tile side (drives command/payload, sinks stream_out)
// modport slave  : encoder side
// ---------------------------------------------------------------------------
interface noc_packet_encoder_if #(
    parameter int XY_SZ     = 4,
    parameter int OFFSET_SZ = 12,
    parameter int LEN_SZ    = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [2*XY_SZ-1:0]   cmd_dest;
    logic [3:0]           cmd_opcode;
    logic [OFFSET_SZ-1:0] cmd_offset;
    logic [LEN_SZ-1:0]    cmd_len;

    logic                 pl_TVALID;
    logic [31:0]          pl_TDATA;
    logic                 pl_TREADY;

    logic                 stream_out_TVALID;
    logic [31:0]          stream_out_TDATA;
    logic [3:0]           stream_out_TKEEP;
    logic                 stream_out_TLAST;
    logic                 stream_out_TREADY;

    modport master (
        output cmd_valid, cmd_dest, cmd_opcode, cmd_offset, cmd_len,
        input  cmd_ready,
        output pl_TVALID, pl_TDATA,
        input  pl_TREADY,
        input  stream_out_TVALID, stream_out_TDATA, stream_out_TKEEP, stream_out_TLAST,
        output stream_out_TREADY
    );

    modport slave (
        input  cmd_valid, cmd_dest, cmd_opcode, cmd_offset, cmd_len,
        output cmd_ready,
        input  pl_TVALID, pl_TDATA,
        output pl_TREADY,
        output stream_out_TVALID, stream_out_TDATA, stream_out_TKEEP, stream_out_TLAST,
        input  stream_out_TREADY
    );

endinterface

// File: rtl/noc_packet_encoder_axis_reg_slice.sv
// ---------------------------------------------------------------------------
// axis_reg_slice: single-entry registered AXI-stream output stage.
//   clk, rst_n      clock, synchronous active-low reset
//   load            write load_data/load_last into the register; the caller
//                   only raises it while slot_free is high
//   slot_free       register empty or being drained this cycle
//   m_valid/m_data/m_keep/m_last/m_ready   registered stream output
// A load in the same cycle as a drain replaces the entry with no gap, so a
// continuous producer gets one word per cycle.
// ---------------------------------------------------------------------------
module axis_reg_slice #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [DATA_W-1:0]   load_data,
    input  logic                load_last,
    output logic                slot_free,
    output logic                m_valid,
    output logic [DATA_W-1:0]   m_data,
    output logic [DATA_W/8-1:0] m_keep,
    output logic                m_last,
    input  logic                m_ready
);

    assign slot_free = !m_valid || m_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_keep  <= '0;
            m_last  <= 1'b0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= load_data;
            m_keep  <= '1;
            m_last  <= load_last;
        end else if (m_ready) begin
            // Drained with nothing behind it: data is left as-is, the
            // qualifiers drop so KEEP/LAST read 0 while invalid.
            m_valid <= 1'b0;
            m_keep  <= '0;
            m_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/noc_packet_encoder.sv
// ---------------------------------------------------------------------------
// noc_packet_encoder: tile transmit-side NoC framer.
//   clk_line, clk_line_rst_low   line clock, synchronous active-low reset
//   HsrcId                       this tile's node ID, captured into the header
//   bus (slave modport)          command, payload stream and NoC output stream
//   busy                         packet in progress or output word pending
//   pkt_count                    packets completed (TLAST handshakes), wraps
// Each accepted command emits one header word
//   {dest, src, opcode, offset}
// followed by cmd_len payload words passed through unmodified; TLAST marks
// the final word (the header itself when cmd_len == 0).
// ---------------------------------------------------------------------------
module noc_packet_encoder
    import noc_pkg::*;
#(
    parameter int XY_SZ     = noc_pkg::XY_SZ,
    parameter int OFFSET_SZ = noc_pkg::OFFSET_SZ,
    parameter int LEN_SZ    = noc_pkg::LEN_SZ
) (
    input  logic                 clk_line,
    input  logic                 clk_line_rst_low,
    input  logic [2*XY_SZ-1:0]   HsrcId,
    noc_packet_encoder_if.slave  bus,
    output logic                 busy,
    output logic [15:0]          pkt_count
);

    if (4*XY_SZ + 4 + OFFSET_SZ != 32) begin : g_bad_hdr_width
        $error("noc_packet_encoder: header fields must total 32 bits");
    end

    enc_state_e        state_q, state_d;
    logic [LEN_SZ-1:0] rem_q, rem_d;

    logic        slot_free;
    logic        load;
    logic [31:0] load_data;
    logic        load_last;
    logic        cmd_ready_c;
    logic        pl_ready_c;
    logic [31:0] header;

    assign header = {bus.cmd_dest, HsrcId, bus.cmd_opcode, bus.cmd_offset};

    // Next state, output-register load and handshakes. Ready is masked
    // while reset is asserted so no command/word is acknowledged and then
    // discarded by the reset branch.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        load        = 1'b0;
        load_data   = '0;
        load_last   = 1'b0;
        cmd_ready_c = 1'b0;
        pl_ready_c  = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_c = clk_line_rst_low && slot_free;
                if (bus.cmd_valid && cmd_ready_c) begin
                    load      = 1'b1;
                    load_data = header;
                    load_last = (bus.cmd_len == '0);
                    rem_d     = bus.cmd_len;
                    state_d   = (bus.cmd_len == '0) ? IDLE : PAYLOAD;
                end
            end
            PAYLOAD: begin
                pl_ready_c = clk_line_rst_low && slot_free;
                if (bus.pl_TVALID && pl_ready_c) begin
                    load      = 1'b1;
                    load_data = bus.pl_TDATA;
                    load_last = (rem_q == LEN_SZ'(1));
                    rem_d     = rem_q - LEN_SZ'(1);
                    if (rem_q == LEN_SZ'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_line) begin
        if (!clk_line_rst_low) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            pkt_count <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            if (bus.stream_out_TVALID && bus.stream_out_TREADY && bus.stream_out_TLAST)
                pkt_count <= pkt_count + 16'd1;
        end
    end

    axis_reg_slice #(
        .DATA_W (32)
    ) u_out_slice (
        .clk       (clk_line),
        .rst_n     (clk_line_rst_low),
        .load      (load),
        .load_data (load_data),
        .load_last (load_last),
        .slot_free (slot_free),
        .m_valid   (bus.stream_out_TVALID),
        .m_data    (bus.stream_out_TDATA),
        .m_keep    (bus.stream_out_TKEEP),
        .m_last    (bus.stream_out_TLAST),
        .m_ready   (bus.stream_out_TREADY)
    );

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.pl_TREADY = pl_ready_c;
    assign busy          = (state_q != IDLE) || bus.stream_out_TVALID;

endmodule

// File: tb/tb_noc_packet_encoder.sv
module tb_noc_packet_encoder;

    localparam logic [7:0] SRC = 8'h03;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  src_id = SRC;
    logic        busy;
    logic [15:0] pkt_count;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    noc_packet_encoder_if #(.XY_SZ(4), .OFFSET_SZ(12), .LEN_SZ(8)) bus ();

    noc_packet_encoder #(.XY_SZ(4), .OFFSET_SZ(12), .LEN_SZ(8)) dut (
        .clk_line         (clk),
        .clk_line_rst_low (rst_n),
        .HsrcId           (src_id),
        .bus              (bus),
        .busy             (busy),
        .pkt_count        (pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cv;
        logic [7:0]  dest;
        logic [3:0]  opc;
        logic [11:0] off;
        logic [7:0]  len;
        logic        pv;
        logic [31:0] pd;
        logic        tr;
        logic        e_cr;
        logic        e_pr;
        logic        e_tv;
        logic [31:0] e_td;
        logic        e_tl;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pl_word(input logic [7:0] tag, input int i);
        logic [31:0] iv;
        iv = i;
        return {8'hA5, tag, iv[15:0]};
    endfunction

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0;
        bus.cmd_dest = '0;
        bus.cmd_opcode = '0;
        bus.cmd_offset = '0;
        bus.cmd_len = '0;
        bus.pl_TVALID = 1'b0;
        bus.pl_TDATA = '0;
        bus.stream_out_TREADY = 1'b1;
    endtask

    // Cycle-accurate packet driver with output scoreboard.
    task automatic run_pkt(input logic [7:0] dest, input logic [3:0] opc, input logic [11:0] off,
                           input int len, input logic [7:0] tag, input bit bp,
                           input int stall_at, input int rst_after, input string nm);
        logic [31:0] exp_q[$];
        logic [31:0] got_d[$];
        logic        got_l[$];
        logic [31:0] lenv;
        int  pl_idx = 0;
        int  cyc = 0;
        int  stall_cnt = 0;
        bit  cmd_done = 0;
        bit  saw_gap = 0;
        bit  started = 0;
        bit  cmd_hs, pl_hs;
        logic pv;
        logic prev_v = 0, prev_r = 0, prev_l = 0;
        logic [31:0] prev_d = '0;
        lenv = len;
        exp_q.push_back({dest, SRC, opc, off});
        for (int i = 0; i < len; i++) exp_q.push_back(pl_word(tag, i));
        while (got_d.size() < len + 1 && cyc < 1000) begin
            bus.cmd_valid  = !cmd_done;
            bus.cmd_dest   = dest;
            bus.cmd_opcode = opc;
            bus.cmd_offset = off;
            bus.cmd_len    = lenv[7:0];
            pv = (pl_idx < len) && !(pl_idx == stall_at && stall_cnt < 5);
            if (pl_idx == stall_at && stall_cnt < 5) stall_cnt++;
            bus.pl_TVALID = pv;
            bus.pl_TDATA  = pv ? pl_word(tag, pl_idx) : 32'h0;
            bus.stream_out_TREADY = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            #1;
            if (prev_v && !prev_r)
                chk({nm, " stable"},
                    {30'h0, bus.stream_out_TVALID, bus.stream_out_TLAST, bus.stream_out_TDATA},
                    {30'h0, 1'b1, prev_l, prev_d});
            if (bus.stream_out_TVALID && !bus.stream_out_TREADY)
                chk({nm, " pl_ready_when_full"}, 64'(bus.pl_TREADY), 64'd0);
            if (started && !bus.stream_out_TVALID) saw_gap = 1;
            if (bus.stream_out_TVALID && bus.stream_out_TREADY) begin
                got_d.push_back(bus.stream_out_TDATA);
                got_l.push_back(bus.stream_out_TLAST);
                chk({nm, " tkeep"}, 64'(bus.stream_out_TKEEP), 64'hF);
                started = 1;
            end
            cmd_hs = bus.cmd_valid && bus.cmd_ready;
            pl_hs  = pv && bus.pl_TREADY;
            prev_v = bus.stream_out_TVALID;
            prev_r = bus.stream_out_TREADY;
            prev_d = bus.stream_out_TDATA;
            prev_l = bus.stream_out_TLAST;
            @(posedge clk);
            #1;
            cyc++;
            if (cmd_hs) cmd_done = 1;
            if (pl_hs) pl_idx++;
            if (rst_after > 0 && pl_hs && pl_idx == rst_after) begin
                idle_inputs();
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                #1;
                exp_cnt = 0;
                chk({nm, " tvalid_after_rst"}, 64'(bus.stream_out_TVALID), 64'd0);
                chk({nm, " pkt_count_after_rst"}, 64'(pkt_count), 64'd0);
                chk({nm, " cmd_ready_after_rst"}, 64'(bus.cmd_ready), 64'd1);
                return;
            end
        end
        chk({nm, " word_count"}, 64'(got_d.size()), 64'(len + 1));
        for (int i = 0; i < got_d.size() && i <= len; i++)
            chk({nm, " word"}, {31'h0, got_l[i], got_d[i]}, {31'h0, (i == len), exp_q[i]});
        if (stall_at >= 0) chk({nm, " tvalid_gap"}, 64'(saw_gap), 64'd1);
        exp_cnt++;
        idle_inputs();
        #1;
        chk({nm, " pkt_count"}, 64'(pkt_count), 64'(exp_cnt));
        chk({nm, " busy_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        //        cv dest   opc   off      len    pv pd         tr  cr pr tv td             tl cnt
        vt[0]  = '{1, 8'h21, 4'h2, 12'h0A5, 8'd0, 0, 32'h0,    1,  1, 0, 0, 32'h0,        0, 16'd0};
        vt[1]  = '{0, 8'h00, 4'h0, 12'h000, 8'd0, 0, 32'h0,    1,  1, 0, 1, 32'h210320A5, 1, 16'd0};
        vt[2]  = '{0, 8'h00, 4'h0, 12'h000, 8'd0, 0, 32'h0,    1,  1, 0, 0, 32'h0,        0, 16'd1};
        vt[3]  = '{1, 8'h21, 4'h1, 12'h000, 8'd3, 1, 32'h11,   1,  1, 0, 0, 32'h0,        0, 16'd1};
        vt[4]  = '{0, 8'h00, 4'h0, 12'h000, 8'd0, 1, 32'h11,   1,  0, 1, 1, 32'h21031000, 0, 16'd1};
        vt[5]  = '{0, 8'h00, 4'h0, 12'h000, 8'd0, 1, 32'h22,   1,  0, 1, 1, 32'h11,       0, 16'd1};
        vt[6]  = '{0, 8'h00, 4'h0, 12'h000, 8'd0, 1, 32'h33,   1,  0, 1, 1, 32'h22,       0, 16'd1};
        vt[7]  = '{0, 8'h00, 4'h0, 12'h000, 8'd0, 0, 32'h0,    1,  1, 0, 1, 32'h33,       1, 16'd1};
        vt[8]  = '{0, 8'h00, 4'h0, 12'h000, 8'd0, 0, 32'h0,    1,  1, 0, 0, 32'h0,        0, 16'd2};
        vt[9]  = '{1, 8'h45, 4'h3, 12'h123, 8'd2, 1, 32'hA1,   1,  1, 0, 0, 32'h0,        0, 16'd2};
        vt[10] = '{1, 8'h67, 4'h4, 12'h456, 8'd0, 1, 32'hA1,   1,  0, 1, 1, 32'h45033123, 0, 16'd2};
        vt[11] = '{1, 8'h67, 4'h4, 12'h456, 8'd0, 1, 32'hA2,   1,  0, 1, 1, 32'hA1,       0, 16'd2};
        vt[12] = '{1, 8'h67, 4'h4, 12'h456, 8'd0, 0, 32'h0,    1,  1, 0, 1, 32'hA2,       1, 16'd2};
        vt[13] = '{0, 8'h00, 4'h0, 12'h000, 8'd0, 0, 32'h0,    1,  1, 0, 1, 32'h67034456, 1, 16'd3};
        vt[14] = '{0, 8'h00, 4'h0, 12'h000, 8'd0, 0, 32'h0,    1,  1, 0, 0, 32'h0,        0, 16'd4};

        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst tvalid", 64'(bus.stream_out_TVALID), 64'd0);
        chk("rst tdata", 64'(bus.stream_out_TDATA), 64'd0);
        chk("rst tkeep", 64'(bus.stream_out_TKEEP), 64'd0);
        chk("rst tlast", 64'(bus.stream_out_TLAST), 64'd0);
        chk("rst pl_ready", 64'(bus.pl_TREADY), 64'd0);
        chk("rst pkt_count", 64'(pkt_count), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst cmd_ready", 64'(bus.cmd_ready), 64'd1);

        for (int i = 0; i < 15; i++) begin
            bus.cmd_valid  = vt[i].cv;
            bus.cmd_dest   = vt[i].dest;
            bus.cmd_opcode = vt[i].opc;
            bus.cmd_offset = vt[i].off;
            bus.cmd_len    = vt[i].len;
            bus.pl_TVALID  = vt[i].pv;
            bus.pl_TDATA   = vt[i].pd;
            bus.stream_out_TREADY = vt[i].tr;
            #1;
            chk($sformatf("vec%0d cmd_ready", i), 64'(bus.cmd_ready), 64'(vt[i].e_cr));
            chk($sformatf("vec%0d pl_ready", i), 64'(bus.pl_TREADY), 64'(vt[i].e_pr));
            chk($sformatf("vec%0d tvalid", i), 64'(bus.stream_out_TVALID), 64'(vt[i].e_tv));
            chk($sformatf("vec%0d tkeep", i), 64'(bus.stream_out_TKEEP), vt[i].e_tv ? 64'hF : 64'h0);
            chk($sformatf("vec%0d pkt_count", i), 64'(pkt_count), 64'(vt[i].e_cnt));
            if (vt[i].e_tv) begin
                chk($sformatf("vec%0d tdata", i), 64'(bus.stream_out_TDATA), 64'(vt[i].e_td));
                chk($sformatf("vec%0d tlast", i), 64'(bus.stream_out_TLAST), 64'(vt[i].e_tl));
            end
            @(posedge clk);
            #1;
        end
        exp_cnt = 4;
        idle_inputs();

        run_pkt(8'h12, 4'h1, 12'h345, 4,   8'h01, 1'b1, -1, -1, "backpressure");
        run_pkt(8'h34, 4'h2, 12'h678, 4,   8'h02, 1'b0,  2, -1, "pl_stall");
        run_pkt(8'h56, 4'h1, 12'h9AB, 5,   8'h03, 1'b0, -1,  2, "rst_mid");
        run_pkt(8'h78, 4'h3, 12'hCDE, 1,   8'h04, 1'b0, -1, -1, "post_rst");
        run_pkt(8'hFF, 4'h4, 12'hFFF, 255, 8'h05, 1'b0, -1, -1, "max_len");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
